// File: rtl/led_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_scan
// Brief    : Column-multiplexed LED matrix driver. Each column gets a blanking
//            phase and then a 2^PWM_BITS-tick ON phase whose duty is set by the
//            brightness sampled on entry to that column. New pixel data is
//            double-buffered and applied only at frame wrap.
// Revision : 1.0 - initial release
// ============================================================================
module led_matrix_scan #(
  parameter int ROWS     = 8,
  parameter int COLS     = 4,
  parameter int DIV      = 12,
  parameter int PWM_BITS = 4,
  parameter int BLANK    = 2
) (
  input  logic                 clk12MHz,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] data,
  input  logic                 latch,
  input  logic [PWM_BITS-1:0]  brightness,
  output logic [ROWS-1:0]      leds,
  output logic [COLS-1:0]      lcol,
  output logic                 frame_start
);

  localparam int c_PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_CW         = $clog2(COLS);
  localparam int c_BW         = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam int c_DIV_LAST   = DIV - 1;
  localparam int c_BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int c_COL_LAST   = COLS - 1;
  localparam logic [PWM_BITS-1:0] c_STEP_LAST = '1;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_t;

  // Without a blanking phase the scan lives permanently in ON.
  localparam state_t c_RST_STATE = (BLANK > 0) ? S_BLANK : S_ON;

  logic [c_PW-1:0]      r_presc,   w_presc_n;
  state_t               r_state,   w_state_n;
  logic [c_CW-1:0]      r_col,     w_col_n;
  logic [PWM_BITS-1:0]  r_step,    w_step_n;
  logic [c_BW-1:0]      r_bcnt,    w_bcnt_n;
  logic [PWM_BITS-1:0]  r_bright,  w_bright_n;
  logic [ROWS*COLS-1:0] r_shadow;
  logic [ROWS*COLS-1:0] r_buf,     w_buf_n;
  logic                 r_pending, w_pending_n;
  logic                 w_tick;
  logic                 w_wrap;
  logic [ROWS-1:0]      w_leds_n;
  logic [COLS-1:0]      w_lcol_n;

  // Next-state of the scan and of the outputs that depict that next state,
  // so leds/lcol register on the same edge as the state they show.
  always_comb begin
    w_tick      = (r_presc == c_DIV_LAST[c_PW-1:0]);
    w_presc_n   = w_tick ? '0 : r_presc + 1'b1;
    w_state_n   = r_state;
    w_col_n     = r_col;
    w_step_n    = r_step;
    w_bcnt_n    = r_bcnt;
    w_bright_n  = r_bright;
    w_wrap      = 1'b0;
    w_buf_n     = r_buf;
    w_pending_n = r_pending;
    w_leds_n    = '0;
    w_lcol_n    = '1;

    if (w_tick) begin
      if (r_state == S_BLANK) begin
        if (r_bcnt == c_BLANK_LAST[c_BW-1:0]) begin
          w_state_n = S_ON;
          w_step_n  = '0;
          w_bcnt_n  = '0;
        end else begin
          w_bcnt_n = r_bcnt + 1'b1;
        end
      end else begin
        if (r_step == c_STEP_LAST) begin
          // Column exit: advance, resample brightness for the new column.
          w_wrap     = (r_col == c_COL_LAST[c_CW-1:0]);
          w_col_n    = w_wrap ? '0 : r_col + 1'b1;
          w_bright_n = brightness;
          w_step_n   = '0;
          w_bcnt_n   = '0;
          w_state_n  = c_RST_STATE;
        end else begin
          w_step_n = r_step + 1'b1;
        end
      end
    end

    // A latch coinciding with the wrap bypasses the shadow register.
    if (w_wrap) begin
      if (latch) begin
        w_buf_n = data;
      end else if (r_pending) begin
        w_buf_n = r_shadow;
      end
      w_pending_n = 1'b0;
    end else if (latch) begin
      w_pending_n = 1'b1;
    end

    if (w_state_n == S_ON) begin
      w_lcol_n = ~(COLS'(1) << w_col_n);
      if (w_step_n < w_bright_n) begin
        w_leds_n = w_buf_n[(COLS - int'(w_col_n))*ROWS - 1 -: ROWS];
      end
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      r_presc     <= '0;
      r_state     <= c_RST_STATE;
      r_col       <= '0;
      r_step      <= '0;
      r_bcnt      <= '0;
      r_bright    <= '0;
      r_shadow    <= '0;
      r_buf       <= '0;
      r_pending   <= 1'b0;
      leds        <= '0;
      lcol        <= '1;
      frame_start <= 1'b0;
    end else begin
      r_presc     <= w_presc_n;
      r_state     <= w_state_n;
      r_col       <= w_col_n;
      r_step      <= w_step_n;
      r_bcnt      <= w_bcnt_n;
      r_bright    <= w_bright_n;
      r_buf       <= w_buf_n;
      r_pending   <= w_pending_n;
      if (latch) begin
        r_shadow <= data;
      end
      leds        <= w_leds_n;
      lcol        <= w_lcol_n;
      frame_start <= w_wrap;
    end
  end

endmodule
`default_nettype wire

// File: doc/led_matrix_scan.md
LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 SHALL have parameter ROWS, default 8, row (LED segment) lines per column.
REQ-002 SHALL have parameter COLS, default 4, column count; legal range 2..16.
REQ-003 SHALL have parameter DIV, default 12, clk12MHz cycles per scan tick; legal range >=1.
REQ-004 SHALL have parameter PWM_BITS, default 4, brightness resolution; ON phase = 2^PWM_BITS ticks.
REQ-005 SHALL have parameter BLANK, default 2, blanking ticks before each column's ON phase; 0 = no blank phase.
REQ-006 SHALL have port clk12MHz  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port data  input  ROWS*COLS  pixel word; column c shows data[(COLS-c)*ROWS-1 -: ROWS].
REQ-009 SHALL have port latch  input  1  capture request for data.
REQ-010 SHALL have port brightness  input  PWM_BITS  global duty setting.
REQ-011 SHALL have port leds  output  ROWS  row drive, active-high.
REQ-012 SHALL have port lcol  output  COLS  column select, active-low, at most one bit low.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse at frame wrap.

Function
REQ-014 Prescaler SHALL count 0..DIV-1 and wrap; a tick SHALL occur on the cycle it equals DIV-1.
REQ-015 Scan FSM SHALL have states BLANK and ON; transitions SHALL happen only on ticks.
REQ-016 BLANK SHALL last BLANK ticks, then go to ON with PWM step 0; with BLANK=0, BLANK SHALL be skipped.
REQ-017 ON SHALL last 2^PWM_BITS ticks (step 0..2^PWM_BITS-1); after the last step, column index SHALL increment and FSM SHALL enter BLANK.
REQ-018 Column index SHALL wrap COLS-1 -> 0; frame_start SHALL be high for exactly the one cycle in which column 0 is re-entered by wrap, never on exit from reset.
REQ-019 brightness SHALL be sampled into a column register on entry to each column (entering BLANK, or ON when BLANK=0) and held for that column.
REQ-020 In ON, lcol SHALL drive bit c low (others high); leds SHALL equal the display-buffer slice for column c when step < sampled brightness, else all zero.
REQ-021 brightness=0 SHALL give leds all zero; maximum brightness SHALL light 2^PWM_BITS-1 of 2^PWM_BITS steps.
REQ-022 In BLANK, lcol SHALL be all ones and leds all zero.
REQ-023 latch=1 SHALL copy data into a shadow register and set a pending flag.
REQ-024 Display buffer SHALL load from shadow only at frame wrap when pending is set, then clear pending; no mid-frame tearing.
REQ-025 latch=1 in the frame-wrap cycle SHALL load data directly into display buffer and leave pending clear.
REQ-026 All outputs SHALL be registered; leds/lcol SHALL change on the same edge as the FSM state they depict.

Reset
REQ-027 rst=1 SHALL force prescaler=0, column=0, step=0, state=BLANK (ON if BLANK=0), shadow=0, display buffer=0, pending=0, sampled brightness=0.
REQ-028 During and after reset, leds SHALL be 0, lcol all ones, frame_start 0.
REQ-029 rst asserted mid-column or mid-frame SHALL take effect on the next edge and discard pending data.
REQ-030 First ON edge of column 0 SHALL be BLANK*DIV edges after the first edge with rst=0.

Verification (ROWS=8, COLS=4, DIV=1, PWM_BITS=2, BLANK=2 unless noted)
REQ-031 Reset release, latch data=32'hA5C3_0FF0 with brightness=3 -> after first wrap, columns show A5, C3, 0F, F0 in order; each column lcol low 4 cycles, leds on 3 of 4; frame period 24 cycles.
REQ-032 brightness=0 then 1 -> zero lit cycles, then one lit cycle per column; change mid-column takes effect only at next column entry.
REQ-033 Latch new data mid-frame -> display unchanged until wrap, new data from column 0; latch in wrap cycle -> new data shown in same frame.
REQ-034 DIV=3, BLANK=0 -> no all-high lcol gap between columns, frame period 48 cycles, frame_start exactly 1 cycle wide every 48.
REQ-035 rst pulsed 1 cycle during column 2 ON -> next edge leds=0, lcol=4'b1111, frame_start=0; scan restarts at column 0 with data 0.
REQ-036 Throughout all tests -> lcol never has more than one bit low; leds zero whenever lcol is all ones.
